// File: rtl/alu_issue_queue_pkg.sv
// alu_issue_queue_pkg
// Shared constants for the ALU issue queue: default geometry, RoB tag width,
// op-code width and the ALU op encodings carried through the queue.
// Optional feature macro used by this block: ALU_IQ_AGE_SELECT_EN
// (oldest-first selection through an age matrix instead of lowest index).
package alu_issue_queue_pkg;

  localparam int IQ_DEPTH_DEF = 8;   // default entry count
  localparam int ROB_ADDR_W   = 4;   // RoB index width (RoB_addr)
  localparam int IQ_OP_W      = 6;   // op code width
  localparam int IQ_N_WB_DEF  = 2;   // default broadcast port count
  localparam int DATA_W       = 32;  // operand width

  typedef enum logic [IQ_OP_W-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5,
    OP_SLL = 6'd6,
    OP_SRL = 6'd7,
    OP_SLT = 6'd8
  } alu_op_e;

endpackage

// File: rtl/alu_iq_select.sv
// alu_iq_select
// Picks one ready entry per cycle from the issue queue.
// With ALU_IQ_AGE_SELECT_EN defined an age matrix is kept (older_reg[i][j]=1
// means entry i is older than entry j) and the oldest ready entry wins.
// Without it, the lowest-index ready entry wins and the age inputs are unused.
// Ports:
//   clk_in, rst_n_in      clock / async active-low reset
//   busy [DEPTH]          registered occupancy (used to age a new entry)
//   ready [DEPTH]         entries with both operands present
//   alloc_en, alloc_idx   an entry is being allocated this cycle
//   sel_onehot, sel_idx   chosen entry (one-hot and binary)
//   found                 at least one entry is ready
module alu_iq_select
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] ready,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  output logic [DEPTH-1:0] sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             found
);

  assign found = |ready;

`ifdef ALU_IQ_AGE_SELECT_EN
  logic [DEPTH-1:0][DEPTH-1:0] older_reg;

  // New entry is younger than everything currently busy; its own row is
  // cleared so it is older than nothing. Stale bits of freed entries are
  // harmless: they are rewritten on that entry's next allocation.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      older_reg <= '0;
    end else if (alloc_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (r == int'(alloc_idx)) older_reg[r] <= '0;
        else                      older_reg[r][alloc_idx] <= busy[r];
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    logic [DEPTH-1:0] older_col;
    always_comb begin
      older_col = '0;
      for (int r = 0; r < DEPTH; r++) older_col[r] = older_reg[r][gi];
    end
    // Ready and no older ready entry exists.
    assign sel_onehot[gi] = ready[gi] && !(|(ready & older_col));
  end
`else
  // Isolate the lowest set bit.
  assign sel_onehot = ready & (~ready + DEPTH'(1));

  logic unused_age_inputs;
  assign unused_age_inputs = ^{clk_in, rst_n_in, busy, alloc_en, alloc_idx};
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_onehot[i]) sel_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
// ALU reservation station: holds up to DEPTH dispatched ops, snoops N_WB
// result-broadcast ports for missing operands and issues one ready op per
// cycle into a registered valid/ready slot towards the ALU.
// Feature macro: ALU_IQ_AGE_SELECT_EN (oldest-first select; see alu_iq_select).
// Ports:
//   clk_in, rst_n_in           clock / async active-low reset
//   rdy_in                     global enable, low freezes all state
//   flush_in                   clears all entries and the issue slot
//   inst_*                     dispatch request and operand info
//   rs_full, rs_count          occupancy from registered busy bits
//   wb_valid/wb_robid/wb_val   packed result broadcasts, port p at slice p
//   alu_valid, alu_ready       issue handshake
//   alu_op/rs1/rs2/id          issued op
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int ROB_W = ROB_ADDR_W,
  parameter int OP_W  = IQ_OP_W,
  parameter int N_WB  = IQ_N_WB_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       inst_valid,
  input  logic [OP_W-1:0]            inst_op,
  input  logic [ROB_W-1:0]           inst_robid,
  input  logic [DATA_W-1:0]          inst_val1,
  input  logic [DATA_W-1:0]          inst_val2,
  input  logic                       inst_has_rely1,
  input  logic                       inst_has_rely2,
  input  logic [ROB_W-1:0]           inst_rely1,
  input  logic [ROB_W-1:0]           inst_rely2,
  output logic                       rs_full,
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  input  logic [N_WB-1:0]            wb_valid,
  input  logic [N_WB*ROB_W-1:0]      wb_robid,
  input  logic [N_WB*DATA_W-1:0]     wb_val,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [OP_W-1:0]            alu_op,
  output logic [DATA_W-1:0]          alu_rs1,
  output logic [DATA_W-1:0]          alu_rs2,
  output logic [ROB_W-1:0]           alu_id
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage
  logic [DEPTH-1:0]  busy_reg, wj_reg, wk_reg;
  logic [OP_W-1:0]   op_reg    [DEPTH];
  logic [ROB_W-1:0]  robid_reg [DEPTH];
  logic [DATA_W-1:0] vj_reg    [DEPTH];
  logic [DATA_W-1:0] vk_reg    [DEPTH];
  logic [ROB_W-1:0]  qj_reg    [DEPTH];
  logic [ROB_W-1:0]  qk_reg    [DEPTH];

  // Unpacked broadcast ports
  logic [ROB_W-1:0]  wb_tag  [N_WB];
  logic [DATA_W-1:0] wb_data [N_WB];

  for (genvar gi = 0; gi < N_WB; gi++) begin : g_wb
    assign wb_tag[gi]  = wb_robid[gi*ROB_W +: ROB_W];
    assign wb_data[gi] = wb_val[gi*DATA_W +: DATA_W];
  end

  // Tag match results; ports scanned high to low so the lowest port wins.
  logic [DEPTH-1:0]  j_hit, k_hit;
  logic [DATA_W-1:0] j_val [DEPTH];
  logic [DATA_W-1:0] k_val [DEPTH];
  logic              d1_hit, d2_hit;
  logic [DATA_W-1:0] d1_val, d2_val;

  always_comb begin
    j_hit  = '0;
    k_hit  = '0;
    d1_hit = 1'b0;
    d2_hit = 1'b0;
    d1_val = '0;
    d2_val = '0;
    for (int e = 0; e < DEPTH; e++) begin
      j_val[e] = '0;
      k_val[e] = '0;
    end
    for (int p = N_WB-1; p >= 0; p--) begin
      if (wb_valid[p]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wb_tag[p] == qj_reg[e]) begin j_hit[e] = 1'b1; j_val[e] = wb_data[p]; end
          if (wb_tag[p] == qk_reg[e]) begin k_hit[e] = 1'b1; k_val[e] = wb_data[p]; end
        end
        if (inst_has_rely1 && wb_tag[p] == inst_rely1) begin d1_hit = 1'b1; d1_val = wb_data[p]; end
        if (inst_has_rely2 && wb_tag[p] == inst_rely2) begin d2_hit = 1'b1; d2_val = wb_data[p]; end
      end
    end
  end

  // Occupancy and free slot
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy_reg[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    rs_count = '0;
    for (int i = 0; i < DEPTH; i++) rs_count = rs_count + CNT_W'(busy_reg[i]);
  end

  assign rs_full = &busy_reg;

  // Selection
  logic [DEPTH-1:0] ready_vec, sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             dispatch_fire, slot_load, issue_fire;

  assign ready_vec     = busy_reg & ~wj_reg & ~wk_reg;
  assign dispatch_fire = rdy_in && !flush_in && inst_valid && !rs_full;
  assign slot_load     = rdy_in && !flush_in && (!alu_valid || alu_ready);
  assign issue_fire    = slot_load && found;

  alu_iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .busy       (busy_reg),
    .ready      (ready_vec),
    .alloc_en   (dispatch_fire),
    .alloc_idx  (free_idx),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .found      (found)
  );

  // Entry state. Dispatch only targets a free entry and issue/wakeup only
  // touch busy entries, so the three never collide on one index.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_reg <= '0;
      wj_reg   <= '0;
      wk_reg   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        op_reg[e]    <= '0;
        robid_reg[e] <= '0;
        vj_reg[e]    <= '0;
        vk_reg[e]    <= '0;
        qj_reg[e]    <= '0;
        qk_reg[e]    <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_reg <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (issue_fire && sel_onehot[e]) busy_reg[e] <= 1'b0;
          if (busy_reg[e] && wj_reg[e] && j_hit[e]) begin
            vj_reg[e] <= j_val[e];
            wj_reg[e] <= 1'b0;
          end
          if (busy_reg[e] && wk_reg[e] && k_hit[e]) begin
            vk_reg[e] <= k_val[e];
            wk_reg[e] <= 1'b0;
          end
        end
        if (dispatch_fire) begin
          busy_reg[free_idx]  <= 1'b1;
          op_reg[free_idx]    <= inst_op;
          robid_reg[free_idx] <= inst_robid;
          qj_reg[free_idx]    <= inst_rely1;
          qk_reg[free_idx]    <= inst_rely2;
          vj_reg[free_idx]    <= d1_hit ? d1_val : inst_val1;
          vk_reg[free_idx]    <= d2_hit ? d2_val : inst_val2;
          wj_reg[free_idx]    <= inst_has_rely1 && !d1_hit;
          wk_reg[free_idx]    <= inst_has_rely2 && !d2_hit;
        end
      end
    end
  end

  // Issue slot
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      alu_id    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        alu_valid <= 1'b0;
      end else if (slot_load) begin
        alu_valid <= found;
        if (found) begin
          alu_op  <= op_reg[sel_idx];
          alu_rs1 <= vj_reg[sel_idx];
          alu_rs2 <= vk_reg[sel_idx];
          alu_id  <= robid_reg[sel_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int N_WB  = 2;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in, rdy_in, flush_in;
  logic                  inst_valid;
  logic [OP_W-1:0]       inst_op;
  logic [ROB_W-1:0]      inst_robid;
  logic [31:0]           inst_val1, inst_val2;
  logic                  inst_has_rely1, inst_has_rely2;
  logic [ROB_W-1:0]      inst_rely1, inst_rely2;
  logic                  rs_full;
  logic [3:0]            rs_count;
  logic [N_WB-1:0]       wb_valid;
  logic [N_WB*ROB_W-1:0] wb_robid;
  logic [N_WB*32-1:0]    wb_val;
  logic                  alu_valid, alu_ready;
  logic [OP_W-1:0]       alu_op;
  logic [31:0]           alu_rs1, alu_rs2;
  logic [ROB_W-1:0]      alu_id;

  always #5 clk_in = ~clk_in;

  alu_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .N_WB(N_WB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_valid(inst_valid), .inst_op(inst_op), .inst_robid(inst_robid),
    .inst_val1(inst_val1), .inst_val2(inst_val2),
    .inst_has_rely1(inst_has_rely1), .inst_has_rely2(inst_has_rely2),
    .inst_rely1(inst_rely1), .inst_rely2(inst_rely2),
    .rs_full(rs_full), .rs_count(rs_count),
    .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_val(wb_val),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_id(alu_id)
  );

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [ROB_W-1:0] id;
  } issue_t;

  issue_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [ROB_W-1:0] id);
    issue_t t;
    t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.id = id;
    sb.push_back(t);
  endtask

  // One clock: observe any handshake that completes at the coming edge,
  // then step past the edge.
  task automatic tick();
    issue_t exp;
    @(negedge clk_in);
    if (rst_n_in && rdy_in && alu_valid && alu_ready) begin
      $display("issue id=%0d op=%0d rs1=%08h rs2=%08h", alu_id, alu_op, alu_rs1, alu_rs2);
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("issue_id",  64'(alu_id),  64'(exp.id));
        chk("issue_op",  64'(alu_op),  64'(exp.op));
        chk("issue_rs1", 64'(alu_rs1), 64'(exp.rs1));
        chk("issue_rs2", 64'(alu_rs2), 64'(exp.rs2));
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] id,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic h1, input logic [ROB_W-1:0] r1,
                          input logic h2, input logic [ROB_W-1:0] r2);
    inst_valid = 1'b1; inst_op = op; inst_robid = id;
    inst_val1 = v1; inst_val2 = v2;
    inst_has_rely1 = h1; inst_rely1 = r1;
    inst_has_rely2 = h2; inst_rely2 = r2;
  endtask

  task automatic clr_disp();
    inst_valid = 1'b0; inst_has_rely1 = 1'b0; inst_has_rely2 = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [ROB_W-1:0] tag, input logic [31:0] v);
    wb_valid[p] = 1'b1;
    wb_robid[p*ROB_W +: ROB_W] = tag;
    wb_val[p*32 +: 32] = v;
  endtask

  task automatic clr_wb();
    wb_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; alu_ready = 1'b1;
    inst_valid = 1'b0; inst_op = '0; inst_robid = '0; inst_val1 = '0; inst_val2 = '0;
    inst_has_rely1 = 1'b0; inst_has_rely2 = 1'b0; inst_rely1 = '0; inst_rely2 = '0;
    wb_valid = '0; wb_robid = '0; wb_val = '0;

    // Reset state
    #12;
    chk("rst_valid", 64'(alu_valid), 64'd0);
    chk("rst_count", 64'(rs_count), 64'd0);
    chk("rst_full",  64'(rs_full), 64'd0);
    chk("rst_id",    64'(alu_id), 64'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    tick();

    // No-dependency op: visible t+1, issued t+2
    set_disp(OP_ADD, 4'd1, 32'h1111_1111, 32'h2222_2222, 1'b0, 4'd0, 1'b0, 4'd0);
    push(OP_ADD, 32'h1111_1111, 32'h2222_2222, 4'd1);
    tick(); clr_disp();
    chk("t1_count", 64'(rs_count), 64'd1);
    chk("t1_valid_t1", 64'(alu_valid), 64'd0);
    tick();
    chk("t1_valid_t2", 64'(alu_valid), 64'd1);
    chk("t1_id", 64'(alu_id), 64'd1);
    tick();
    chk("t1_valid_after", 64'(alu_valid), 64'd0);
    chk("t1_count_after", 64'(rs_count), 64'd0);

    // Dispatch-time bypass from port 1
    set_disp(OP_SUB, 4'd4, 32'hDEAD, 32'h77, 1'b1, 4'd3, 1'b0, 4'd0);
    set_wb(1, 4'd3, 32'h55);
    push(OP_SUB, 32'h55, 32'h77, 4'd4);
    tick(); clr_disp(); clr_wb();
    tick();
    chk("t2_valid", 64'(alu_valid), 64'd1);
    chk("t2_rs1", 64'(alu_rs1), 64'h55);
    drain(4);

    // Fill all entries, each waiting on tag i
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(OP_AND, 4'(8+i), 32'hF000 + 32'(i), 32'(i), 1'b1, 4'(i), 1'b0, 4'd0);
      tick();
    end
    clr_disp();
    chk("fill_full", 64'(rs_full), 64'd1);
    chk("fill_count", 64'(rs_count), 64'd8);
    set_disp(OP_OR, 4'd7, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); clr_disp();
    chk("full_drop_count", 64'(rs_count), 64'd8);
    chk("full_drop_valid", 64'(alu_valid), 64'd0);
    set_wb(0, 4'd5, 32'hA5);
    push(OP_AND, 32'hA5, 32'd5, 4'd13);
    tick(); clr_wb();
    chk("wake_full_still", 64'(rs_full), 64'd1);
    tick();
    chk("wake_valid", 64'(alu_valid), 64'd1);
    chk("wake_id", 64'(alu_id), 64'd13);
    chk("wake_full_drop", 64'(rs_full), 64'd0);
    chk("wake_count", 64'(rs_count), 64'd7);
    drain(4);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 5) begin
        set_wb(0, 4'(i), 32'hC0 + 32'(i));
        if (i == 0) set_wb(1, 4'd0, 32'hBAD0);   // port 0 must win
        push(OP_AND, 32'hC0 + 32'(i), 32'(i), 4'(8+i));
        tick(); clr_wb();
      end
    end
    drain(8);
    chk("fill_empty", 64'(rs_count), 64'd0);

    // Age order: robid 5 at index 4 (older), robid 2 at index 0 (younger)
    set_disp(OP_XOR, 4'd12, 32'h12, 32'h34, 1'b1, 4'd14, 1'b0, 4'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_XOR, 4'(13+i), 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0);
      tick();
    end
    set_disp(OP_ADD, 4'd5, 32'd0, 32'h500, 1'b1, 4'd10, 1'b0, 4'd0);
    tick(); clr_disp();
    set_wb(0, 4'd14, 32'hE0);
    push(OP_XOR, 32'hE0, 32'h34, 4'd12);
    tick(); clr_wb();
    drain(4);
    chk("age_count4", 64'(rs_count), 64'd4);
    set_disp(OP_SUB, 4'd2, 32'h200, 32'd0, 1'b0, 4'd0, 1'b1, 4'd11);
    tick(); clr_disp();
    set_wb(0, 4'd10, 32'hAA);
    set_wb(1, 4'd11, 32'hBB);
`ifdef ALU_IQ_AGE_SELECT_EN
    push(OP_ADD, 32'hAA, 32'h500, 4'd5);
    push(OP_SUB, 32'h200, 32'hBB, 4'd2);
`else
    push(OP_SUB, 32'h200, 32'hBB, 4'd2);
    push(OP_ADD, 32'hAA, 32'h500, 4'd5);
`endif
    tick(); clr_wb();
    drain(6);
    chk("age_count3", 64'(rs_count), 64'd3);

    // rdy_in low freezes dispatch
    rdy_in = 1'b0;
    set_disp(OP_ADD, 4'd3, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); clr_disp();
    rdy_in = 1'b1;
    chk("frozen_count", 64'(rs_count), 64'd3);
    chk("frozen_valid", 64'(alu_valid), 64'd0);

    // Stall: slot holds, nothing freed
    alu_ready = 1'b0;
    set_disp(OP_SLL, 4'd6, 32'h600, 32'h601, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    set_disp(OP_SRL, 4'd9, 32'h900, 32'h901, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); clr_disp();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 64'(alu_valid), 64'd1);
      chk("stall_id", 64'(alu_id), 64'd6);
      chk("stall_rs1", 64'(alu_rs1), 64'h600);
      chk("stall_count", 64'(rs_count), 64'd4);
      tick();
    end

    // Flush with busy entries, valid slot and simultaneous dispatch
    flush_in = 1'b1;
    set_disp(OP_ADD, 4'd12, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); clr_disp();
    flush_in = 1'b0;
    chk("flush_count", 64'(rs_count), 64'd0);
    chk("flush_valid", 64'(alu_valid), 64'd0);
    chk("flush_full", 64'(rs_full), 64'd0);
    alu_ready = 1'b1;
    tick(); tick();
    chk("flush_drop_valid", 64'(alu_valid), 64'd0);
    chk("flush_drop_count", 64'(rs_count), 64'd0);

    // Asynchronous reset mid-stream
    alu_ready = 1'b0;
    set_disp(OP_SLT, 4'd1, 32'h100, 32'h101, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); clr_disp();
    tick();
    chk("arst_pre_valid", 64'(alu_valid), 64'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 64'(alu_valid), 64'd0);
    chk("arst_op",    64'(alu_op), 64'd0);
    chk("arst_rs1",   64'(alu_rs1), 64'd0);
    chk("arst_rs2",   64'(alu_rs2), 64'd0);
    chk("arst_id",    64'(alu_id), 64'd0);
    chk("arst_count", 64'(rs_count), 64'd0);
    chk("arst_full",  64'(rs_full), 64'd0);
    tick();
    rst_n_in = 1'b1;
    tick();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
